// File: rtl/hrm_pkg.sv
// Shared HRM CPU definitions: opcodes, ALU selects,
// R-source selects and the control bundle.
package hrm_pkg;

  localparam logic [3:0] OP_INBOX    = 4'd0;
  localparam logic [3:0] OP_OUTBOX   = 4'd1;
  localparam logic [3:0] OP_COPYFROM = 4'd2;
  localparam logic [3:0] OP_COPYTO   = 4'd3;
  localparam logic [3:0] OP_ADD      = 4'd4;
  localparam logic [3:0] OP_SUB      = 4'd5;
  localparam logic [3:0] OP_BUMPP    = 4'd6;
  localparam logic [3:0] OP_BUMPM    = 4'd7;
  localparam logic [3:0] OP_JUMP     = 4'd8;
  localparam logic [3:0] OP_JUMPZ    = 4'd9;
  localparam logic [3:0] OP_JUMPN    = 4'd10;
  localparam logic [3:0] OP_CPF_IND  = 4'd11;
  localparam logic [3:0] OP_CPT_IND  = 4'd12;
  localparam logic [3:0] OP_ADD_IND  = 4'd13;
  localparam logic [3:0] OP_SUB_IND  = 4'd14;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_INC  = 3'b010;
  localparam logic [2:0] ALU_DEC  = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;
  localparam logic [2:0] ALU_ZERO = 3'b101;
  localparam logic [2:0] ALU_NEG  = 3'b110;

  localparam logic [1:0] MUXR_IN  = 2'b00;
  localparam logic [1:0] MUXR_MEM = 2'b01;
  localparam logic [1:0] MUXR_ALU = 2'b10;

  typedef struct packed {
    logic [1:0] muxR;
    logic       wR;
    logic       muxM;
    logic       wM;
    logic [2:0] aluCtl;
    logic       branch;
    logic       ijump;
    logic       rIn;
    logic       wO;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode to control-bundle table.
// Unmatched (reserved or unknown) opcodes decode to NOP.
module control_decode
  import hrm_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_INBOX: begin
        ctrl.muxR = MUXR_IN;
        ctrl.wR   = 1'b1;
        ctrl.rIn  = 1'b1;
      end
      OP_OUTBOX: ctrl.wO = 1'b1;
      OP_COPYFROM: begin
        ctrl.muxR = MUXR_MEM;
        ctrl.wR   = 1'b1;
      end
      OP_COPYTO: begin
        ctrl.wM     = 1'b1;
        ctrl.aluCtl = ALU_PASS;
      end
      OP_ADD: begin
        ctrl.muxR   = MUXR_ALU;
        ctrl.wR     = 1'b1;
        ctrl.aluCtl = ALU_ADD;
      end
      OP_SUB: begin
        ctrl.muxR   = MUXR_ALU;
        ctrl.wR     = 1'b1;
        ctrl.aluCtl = ALU_SUB;
      end
      OP_BUMPP: begin
        ctrl.muxR   = MUXR_ALU;
        ctrl.wR     = 1'b1;
        ctrl.wM     = 1'b1;
        ctrl.aluCtl = ALU_INC;
      end
      OP_BUMPM: begin
        ctrl.muxR   = MUXR_ALU;
        ctrl.wR     = 1'b1;
        ctrl.wM     = 1'b1;
        ctrl.aluCtl = ALU_DEC;
      end
      OP_JUMP: ctrl.ijump = 1'b1;
      OP_JUMPZ: begin
        ctrl.branch = 1'b1;
        ctrl.aluCtl = ALU_ZERO;
      end
      OP_JUMPN: begin
        ctrl.branch = 1'b1;
        ctrl.aluCtl = ALU_NEG;
      end
      OP_CPF_IND: begin
        ctrl.muxR = MUXR_MEM;
        ctrl.wR   = 1'b1;
        ctrl.muxM = 1'b1;
      end
      OP_CPT_IND: begin
        ctrl.wM     = 1'b1;
        ctrl.muxM   = 1'b1;
        ctrl.aluCtl = ALU_PASS;
      end
      OP_ADD_IND: begin
        ctrl.muxR   = MUXR_ALU;
        ctrl.wR     = 1'b1;
        ctrl.muxM   = 1'b1;
        ctrl.aluCtl = ALU_ADD;
      end
      OP_SUB_IND: begin
        ctrl.muxR   = MUXR_ALU;
        ctrl.wR     = 1'b1;
        ctrl.muxM   = 1'b1;
        ctrl.aluCtl = ALU_SUB;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Registered HRM instruction decoder: one-cycle latency,
// all outputs cleared to NOP by synchronous reset.
module control_unit
  import hrm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  output logic [1:0] muxR,
  output logic       wR,
  output logic       muxM,
  output logic       wM,
  output logic [2:0] aluCtl,
  output logic       branch,
  output logic       ijump,
  output logic       rIn,
  output logic       wO
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  control_decode u_dec (
    .opcode (opcode),
    .ctrl   (ctrl_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign muxR   = ctrl_q.muxR;
  assign wR     = ctrl_q.wR;
  assign muxM   = ctrl_q.muxM;
  assign wM     = ctrl_q.wM;
  assign aluCtl = ctrl_q.aluCtl;
  assign branch = ctrl_q.branch;
  assign ijump  = ctrl_q.ijump;
  assign rIn    = ctrl_q.rIn;
  assign wO     = ctrl_q.wO;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit.
// Field order: muxR wR muxM wM aluCtl branch ijump rIn wO.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic [1:0] muxR;
  logic       wR, muxM, wM;
  logic [2:0] aluCtl;
  logic       branch, ijump, rIn, wO;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .muxR   (muxR),
    .wR     (wR),
    .muxM   (muxM),
    .wM     (wM),
    .aluCtl (aluCtl),
    .branch (branch),
    .ijump  (ijump),
    .rIn    (rIn),
    .wO     (wO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  op;
    logic [11:0] exp;
  } vec_t;

  logic [11:0] tab [16];
  vec_t        vecs [24];

  function automatic logic [11:0] outs();
    return {muxR, wR, muxM, wM, aluCtl, branch, ijump, rIn, wO};
  endfunction

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] op);
    @(negedge clk);
    rst_n  = r;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tab[0]  = 12'b00_1_0_0_000_0_0_1_0;
    tab[1]  = 12'b00_0_0_0_000_0_0_0_1;
    tab[2]  = 12'b01_1_0_0_000_0_0_0_0;
    tab[3]  = 12'b00_0_0_1_100_0_0_0_0;
    tab[4]  = 12'b10_1_0_0_000_0_0_0_0;
    tab[5]  = 12'b10_1_0_0_001_0_0_0_0;
    tab[6]  = 12'b10_1_0_1_010_0_0_0_0;
    tab[7]  = 12'b10_1_0_1_011_0_0_0_0;
    tab[8]  = 12'b00_0_0_0_000_0_1_0_0;
    tab[9]  = 12'b00_0_0_0_101_1_0_0_0;
    tab[10] = 12'b00_0_0_0_110_1_0_0_0;
    tab[11] = 12'b01_1_1_0_000_0_0_0_0;
    tab[12] = 12'b00_0_1_1_100_0_0_0_0;
    tab[13] = 12'b10_1_1_0_000_0_0_0_0;
    tab[14] = 12'b10_1_1_0_001_0_0_0_0;
    tab[15] = 12'b00_0_0_0_000_0_0_0_0;

    vecs[0] = '{1'b0, 4'd4, 12'h000};
    vecs[1] = '{1'b0, 4'd4, 12'h000};
    vecs[2] = '{1'b1, 4'd4, 12'b10_1_0_0_000_0_0_0_0};
    for (int i = 0; i < 16; i++)
      vecs[3+i] = '{1'b1, 4'(i), tab[i]};
    vecs[19] = '{1'b1, 4'd3, tab[3]};
    vecs[20] = '{1'b0, 4'd6, 12'h000};
    vecs[21] = '{1'b1, 4'd10, 12'b00_0_0_0_110_1_0_0_0};
    vecs[22] = '{1'b1, 4'd15, 12'h000};
    vecs[23] = '{1'b1, 4'd0, 12'b00_1_0_0_000_0_0_1_0};

    rst_n  = 1'b0;
    opcode = 4'd4;

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].op);
      check($sformatf("vec%0d_op%0d_rst%0b", i, vecs[i].op,
                      vecs[i].rst_n), vecs[i].exp);
    end

    // reserved then unknown opcode
    step(1'b1, 4'd15);
    check("reserved_15", 12'h000);
    begin
      logic [3:0] xop;
      logic [11:0] e;
      xop = 4'bx;
      step(1'b1, xop);
      e = $isunknown(opcode) ? 12'h000 : tab[opcode];
      check("unknown_op", e);
    end

    // latency: opcode changes between edges
    step(1'b1, 4'd8);
    check("lat_jump", tab[8]);
    #2 opcode = 4'd1;
    #1 check("lat_hold", tab[8]);
    @(negedge clk);
    check("lat_hold_neg", tab[8]);
    @(posedge clk);
    #1 check("lat_outbox", tab[1]);

    // random stream with invariant monitor
    for (int n = 0; n < 1000; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      step(1'b1, op);
      check($sformatf("rand%0d_op%0d", n, op), tab[op]);
      checks++;
      if ((branch && ijump) || muxR == 2'b11 ||
          (rIn && !(wR && muxR == 2'b00))) begin
        errors++;
        $display("FAIL invariant cycle %0d: got %b", n, outs());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Registered instruction decoder for the HRM single-cycle CPU.
- Maps a 4-bit opcode to the datapath control strobes: R-register source/write, memory address mode/write, ALU operation, branch/jump, inbox read and outbox write.
- Sits between the instruction register and the datapath (register R, data memory, ALU, PC logic, inbox/outbox FIFOs).

Parameters:
- None. Widths are fixed by the ISA: opcode 4 bits, muxR 2 bits, aluCtl 3 bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  synchronous reset, active-low
- opcode  input  4  current instruction opcode
- muxR  output  2  R source select: 00 inbox, 01 memory data, 10 ALU result, 11 unused
- wR  output  1  write enable for register R
- muxM  output  1  memory address select: 0 direct operand, 1 indirect (address read from memory)
- wM  output  1  data-memory write enable; write data is always the ALU output
- aluCtl  output  3  ALU operation select (encodings below)
- branch  output  1  conditional jump; taken when the ALU flag selected by aluCtl is true
- ijump  output  1  unconditional jump
- rIn  output  1  inbox read/dequeue strobe
- wO  output  1  outbox write strobe (writes R)

Behaviour:
- Reset and latency:
  - All outputs are registered.
  - When rst_n=0 at a rising clk edge, every output becomes 0 on that edge. The all-zero state is a NOP.
  - Otherwise each output is updated to decode(opcode) on the edge. Latency is 1 cycle; there is no combinational path from opcode to any output.
- aluCtl encodings:
  - 000 ADD (R+M)
  - 001 SUB (R−M)
  - 010 INC (M+1)
  - 011 DEC (M−1)
  - 100 PASS R
  - 101 ZERO test (R==0)
  - 110 NEG test (R<0)
  - 111 reserved, never emitted
- Decode table. Any field not listed is 0:
  - 0 INBOX: muxR=00 wR=1 rIn=1
  - 1 OUTBOX: wO=1
  - 2 COPYFROM: muxR=01 wR=1
  - 3 COPYTO: wM=1 aluCtl=100
  - 4 ADD: muxR=10 wR=1 aluCtl=000
  - 5 SUB: muxR=10 wR=1 aluCtl=001
  - 6 BUMP+: muxR=10 wR=1 wM=1 aluCtl=010
  - 7 BUMP−: muxR=10 wR=1 wM=1 aluCtl=011
  - 8 JUMP: ijump=1
  - 9 JUMPZ: branch=1 aluCtl=101
  - 10 JUMPN: branch=1 aluCtl=110
  - 11 COPYFROM*: muxR=01 wR=1 muxM=1
  - 12 COPYTO*: wM=1 muxM=1 aluCtl=100
  - 13 ADD*: muxR=10 wR=1 muxM=1 aluCtl=000
  - 14 SUB*: muxR=10 wR=1 muxM=1 aluCtl=001
  - 15 reserved: all outputs 0 (NOP)
- Invariants, true in every cycle:
  - branch and ijump are never both 1.
  - rIn=1 implies muxR=00 and wR=1.
  - muxR is never 11.
  - X or Z on opcode is treated as reserved and produces all-zero outputs.
- Reset mid-operation: reset takes priority over any opcode. Outputs are 0 on the first edge with rst_n=0 and stay 0 while rst_n=0. Decoding resumes on the first edge with rst_n=1.

Decomposition:
- Shared package hrm_pkg holds:
  - opcode localparams (OP_INBOX … OP_SUB_IND)
  - aluCtl localparams (ALU_ADD … ALU_NEG)
  - muxR localparams (MUXR_IN, MUXR_MEM, MUXR_ALU)
  - a packed ctrl_t struct bundling all control fields
- One natural sub-module, control_decode: a purely combinational opcode→ctrl_t table. control_unit wraps it with the reset-able output register.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with opcode=4 → all outputs 0. Release rst_n; one edge later → muxR=10 wR=1 aluCtl=000.
- Full sweep: opcode 0..15, one per cycle → each output set matches the decode table one cycle later. Spot checks:
  - opcode 0 → muxR=00 wR=1 rIn=1
  - opcode 9 → branch=1 aluCtl=101
  - opcode 12 → wM=1 muxM=1 aluCtl=100
- Reserved/unknown: opcode=15, then opcode=4'bx → all outputs 0 in both following cycles.
- Latency: change opcode from 8 to 1 between edges → ijump stays 1 until the next edge, then ijump=0 wO=1. Outputs never change between edges.
- Reset mid-stream: during a sweep, assert rst_n=0 while opcode=6 → outputs 0 that edge. Deassert with opcode=10 → branch=1 aluCtl=110 next edge.
- Invariant monitor over a random 1000-cycle opcode stream:
  - never branch&&ijump
  - never muxR=11
  - rIn implies (wR && muxR==00)
